// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the execute stage and the data-memory port.
// Computes the effective address, lane-aligns store data and byte enables, runs
// a req/gnt/rvalid handshake, and returns sign/zero-extended load data.
// Optional response watchdog: define LSU_TIMEOUT_EN (limit set by TIMEOUT_CYC).
module lsu_ctrl #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [11:0]         imm,
  input  logic [XLEN-1:0]     op0,
  input  logic [XLEN-1:0]     op1,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                res_valid,
  output logic [XLEN-1:0]     res_data,
  output logic                misalign,
  output logic                fault
);

  localparam int BEW   = XLEN / 8;
  localparam int OFF_W = $clog2(BEW);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic                misalign_q, misalign_d;
  logic                fault_q, fault_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic [BEW-1:0]      be_q;
  logic                we_q;
  logic [OFF_W-1:0]    off_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [XLEN-1:0]     data_q;

  logic                accept, is_ld, is_st, misal_a;
  logic signed [XLEN-1:0] ea;
  logic [OFF_W-1:0]    off_a;
  logic [BEW-1:0]      be_m, be_a;
  logic [XLEN-1:0]     data_m, wdata_a;
  int                  szb;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tmo;
  assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  // Select size bytes at the lane offset, then zero- or sign-extend to XLEN.
  function automatic logic [XLEN-1:0] ext_load(input logic [XLEN-1:0] s,
                                               input logic [1:0] sz,
                                               input logic uns);
    logic [XLEN-1:0] r;
    int              nb;
    logic            sb;
    nb = 8 << sz;
    if (nb > XLEN) nb = XLEN;
    sb = s[nb-1];
    for (int i = 0; i < XLEN; i++)
      r[i] = (i < nb) ? s[i] : (~uns & sb);
    return r;
  endfunction

  assign accept = in_valid & (state_q == IDLE);
  assign is_ld  = (opcode == OP_LOAD);
  assign is_st  = (opcode == OP_STORE);
  assign ea     = $signed(op0) + XLEN'($signed(imm));
  assign off_a  = ea[OFF_W-1:0];

  // Accept-side decode: misalignment, lane-shifted byte enables and store data.
  always_comb begin
    szb     = 1 << funct3[1:0];
    misal_a = (szb > BEW) || ((int'(ea[3:0]) & (szb - 1)) != 0);
    be_m    = '0;
    data_m  = '0;
    for (int i = 0; i < BEW; i++) begin
      be_m[i]         = (i < szb);
      data_m[i*8 +: 8] = (i < szb) ? op1[i*8 +: 8] : 8'h00;
    end
    be_a    = be_m << off_a;
    wdata_a = data_m << {off_a, 3'b000};
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      misalign_q <= misalign_d;
      fault_q    <= fault_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Next-state logic for the IDLE/REQ/WAIT/DONE handshake.
  always_comb begin
    state_d    = state_q;
    misalign_d = misalign_q;
    fault_d    = fault_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept && (is_ld || is_st)) begin
          misalign_d = misal_a;
          fault_d    = 1'b0;
          state_d    = misal_a ? DONE : REQ;
`ifdef LSU_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      REQ: begin
        if (mem_gnt) state_d = we_q ? DONE : WAIT;
`ifdef LSU_TIMEOUT_EN
        else if (tmo) begin
          state_d = DONE;
          fault_d = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
`endif
      end
      WAIT: begin
        if (mem_rvalid) state_d = DONE;
`ifdef LSU_TIMEOUT_EN
        else if (tmo) begin
          state_d = DONE;
          fault_d = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields latched at accept; load data captured on the response.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= ADDR_W'(ea);
      wdata_q <= wdata_a;
      be_q    <= be_a;
      we_q    <= is_st;
      off_q   <= off_a;
      size_q  <= funct3[1:0];
      uns_q   <= funct3[2];
      data_q  <= '0;
    end else if (state_q == WAIT && mem_rvalid) begin
      data_q  <= ext_load(mem_rdata >> {off_q, 3'b000}, size_q, uns_q);
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? addr_q  : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;
  assign mem_be    = mem_req ? be_q    : '0;
  assign res_valid = (state_q == DONE);
  assign res_data  = res_valid ? data_q : '0;
  assign misalign  = res_valid & misalign_q;
`ifdef LSU_TIMEOUT_EN
  assign fault     = res_valid & fault_q;
`else
  assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl (XLEN=32, TIMEOUT_CYC=8).
module tb_lsu_ctrl;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [11:0] imm;
  logic [31:0] op0, op1;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        res_valid, misalign, fault;
  logic [31:0] res_data;

  int errors = 0;
  int checks = 0;

  lsu_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .imm(imm), .op0(op0), .op1(op1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .res_valid(res_valid),
    .res_data(res_data), .misalign(misalign), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [6:0] opc, input logic [2:0] f3,
                       input logic [11:0] im, input logic [31:0] a,
                       input logic [31:0] d);
    opcode = opc; funct3 = f3; imm = im; op0 = a; op1 = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    checks++;
    if ({in_ready, mem_req, mem_we, res_valid, misalign, fault} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b exp 100000",
               {in_ready, mem_req, mem_we, res_valid, misalign, fault});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_be, res_data} !== 100'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h be=%h res=%h exp all 0",
               mem_addr, mem_wdata, mem_be, res_data);
    end
  endtask

  task automatic test_lw();
    offer(LD, 3'd2, 12'hFFC, 32'h0000_1000, 32'h0);
    checks++;
    if ({mem_req, mem_we, in_ready, mem_be, mem_addr} !== {3'b100, 4'hF, 32'h0000_0FFC}) begin
      errors++;
      $display("FAIL lw_req: req=%b we=%b rdy=%b be=%h addr=%h exp 1 0 0 f 00000ffc",
               mem_req, mem_we, in_ready, mem_be, mem_addr);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    checks++;
    if ({mem_req, res_valid} !== 2'b00) begin
      errors++;
      $display("FAIL lw_wait: req=%b res_valid=%b exp 0 0", mem_req, res_valid);
    end
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if ({res_valid, misalign, fault, res_data} !== {3'b100, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL lw_done: vld=%b mis=%b flt=%b data=%h exp 1 0 0 deadbeef",
               res_valid, misalign, fault, res_data);
    end
    tick();
    checks++;
    if ({res_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL lw_idle: vld=%b rdy=%b exp 0 1", res_valid, in_ready);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3_t   [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [11:0] imm_t  [4] = '{12'h003, 12'h003, 12'h002, 12'h002};
    logic [3:0]  be_t   [4] = '{4'h8, 4'h8, 4'hC, 4'hC};
    logic [31:0] rd_t   [4] = '{32'h80AA_BBCC, 32'h80AA_BBCC, 32'h8001_1234, 32'h8001_1234};
    logic [31:0] exp_t  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
    for (int i = 0; i < 4; i++) begin
      offer(LD, f3_t[i], imm_t[i], 32'h0000_2000, 32'h0);
      checks++;
      if ({mem_req, mem_be} !== {1'b1, be_t[i]}) begin
        errors++;
        $display("FAIL ext_be[%0d]: req=%b be=%h exp 1 %h", i, mem_req, mem_be, be_t[i]);
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd_t[i];
      tick();
      mem_rvalid = 1'b0;
      checks++;
      if ({res_valid, res_data} !== {1'b1, exp_t[i]}) begin
        errors++;
        $display("FAIL ext_data[%0d]: vld=%b data=%h exp 1 %h", i, res_valid, res_data, exp_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3_t [2] = '{3'd1, 3'd0};
    logic [11:0] im_t [2] = '{12'h002, 12'h001};
    logic [31:0] d_t  [2] = '{32'h1234_ABCD, 32'h0000_00A5};
    logic [31:0] a_t  [2] = '{32'h0000_0102, 32'h0000_0101};
    logic [3:0]  be_t [2] = '{4'hC, 4'h2};
    logic [31:0] w_t  [2] = '{32'hABCD_0000, 32'h0000_A500};
    for (int i = 0; i < 2; i++) begin
      offer(ST, f3_t[i], im_t[i], 32'h0000_0100, d_t[i]);
      checks++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {2'b11, be_t[i], a_t[i], w_t[i]}) begin
        errors++;
        $display("FAIL st_req[%0d]: req=%b we=%b be=%h addr=%h wdata=%h exp 1 1 %h %h %h",
                 i, mem_req, mem_we, mem_be, mem_addr, mem_wdata, be_t[i], a_t[i], w_t[i]);
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      checks++;
      if ({res_valid, mem_req, misalign, res_data} !== {3'b100, 32'h0}) begin
        errors++;
        $display("FAIL st_done[%0d]: vld=%b req=%b mis=%b data=%h exp 1 0 0 0",
                 i, res_valid, mem_req, misalign, res_data);
      end
      tick();
    end
  endtask

  task automatic test_misalign();
    // LW at EA 0x6, then LD (illegal at XLEN=32) at an 8-byte aligned EA.
    logic [2:0]  f3_t [2] = '{3'd2, 3'd3};
    logic [11:0] im_t [2] = '{12'h002, 12'h004};
    for (int i = 0; i < 2; i++) begin
      offer(LD, f3_t[i], im_t[i], 32'h0000_0004, 32'h0);
      checks++;
      if ({mem_req, res_valid, misalign, fault, res_data} !== {4'b0110, 32'h0}) begin
        errors++;
        $display("FAIL misalign[%0d]: req=%b vld=%b mis=%b flt=%b data=%h exp 0 1 1 0 0",
                 i, mem_req, res_valid, misalign, fault, res_data);
      end
      tick();
      checks++;
      if ({res_valid, in_ready, mem_req} !== 3'b010) begin
        errors++;
        $display("FAIL misalign_idle[%0d]: vld=%b rdy=%b req=%b exp 0 1 0",
                 i, res_valid, in_ready, mem_req);
      end
    end
  endtask

  task automatic test_illegal_opcode();
    offer(7'b0110011, 3'd2, 12'h000, 32'h0, 32'h0);
    checks++;
    if ({in_ready, mem_req, res_valid} !== 3'b100) begin
      errors++;
      $display("FAIL bad_opcode: rdy=%b req=%b vld=%b exp 1 0 0", in_ready, mem_req, res_valid);
    end
    tick();
    checks++;
    if ({in_ready, res_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bad_opcode_later: rdy=%b vld=%b exp 1 0", in_ready, res_valid);
    end
  endtask

  task automatic test_gnt_stall();
    offer(LD, 3'd2, 12'h010, 32'h0000_3000, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({mem_req, in_ready, res_valid, mem_addr} !== {3'b100, 32'h0000_3010}) begin
        errors++;
        $display("FAIL stall[%0d]: req=%b rdy=%b vld=%b addr=%h exp 1 0 0 00003010",
                 k, mem_req, in_ready, res_valid, mem_addr);
      end
      tick();
    end
    mem_rvalid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checks++;
    if ({mem_req, in_ready, res_valid} !== 3'b000) begin
      errors++;
      $display("FAIL stall_wait: req=%b rdy=%b vld=%b exp 0 0 0", mem_req, in_ready, res_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({mem_req, in_ready, res_valid} !== 3'b010) begin
      errors++;
      $display("FAIL rst_wait: req=%b rdy=%b vld=%b exp 0 1 0", mem_req, in_ready, res_valid);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if ({res_valid, in_ready, res_data} !== {2'b01, 32'h0}) begin
      errors++;
      $display("FAIL late_rvalid: vld=%b rdy=%b data=%h exp 0 1 0", res_valid, in_ready, res_data);
    end
  endtask

  task automatic test_reset_req();
    offer(ST, 3'd2, 12'h000, 32'h0000_0040, 32'hCAFE_F00D);
    checks++;
    if ({mem_req, mem_we, mem_wdata} !== {2'b11, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL rst_req_pre: req=%b we=%b wdata=%h exp 1 1 cafef00d", mem_req, mem_we, mem_wdata);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({mem_req, in_ready, res_valid} !== 3'b010) begin
      errors++;
      $display("FAIL rst_req: req=%b rdy=%b vld=%b exp 0 1 0", mem_req, in_ready, res_valid);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    offer(LD, 3'd2, 12'h000, 32'h0000_0800, 32'h0);
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++;
      if ({mem_req, res_valid} !== 2'b10) begin
        errors++;
        $display("FAIL tmo_hold[%0d]: req=%b vld=%b exp 1 0", k, mem_req, res_valid);
      end
    end
    tick();
    checks++;
    if ({res_valid, fault, misalign, mem_req, res_data} !== {4'b1100, 32'h0}) begin
      errors++;
      $display("FAIL tmo_done: vld=%b flt=%b mis=%b req=%b data=%h exp 1 1 0 0 0",
               res_valid, fault, misalign, mem_req, res_data);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if ({res_valid, fault, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL tmo_late: vld=%b flt=%b rdy=%b exp 0 0 1", res_valid, fault, in_ready);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; funct3 = '0; imm = '0;
    op0 = '0; op1 = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misalign();
    test_illegal_opcode();
    test_gnt_stall();
    test_reset_req();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Parametrised load/store unit; successor to the single-cycle address/store-data stage.
- Takes one load/store from the execute stage and computes the effective address.
- Generates a byte-lane-aligned write strobe, runs a request/grant/response handshake to data memory, and returns sign- or zero-extended load data.
- Detects misaligned accesses and sits between the execute stage and the data-memory port.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. 64 enables LD/SD/LWU.
- ADDR_W, 32, memory address width; effective address is truncated to ADDR_W.
- TIMEOUT_CYC, 255, response watchdog limit in cycles. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit idle and able to accept.
- opcode  in  7  7'b0000011 is load; 7'b0100011 is store.
- funct3  in  3  [1:0] is size (0=B, 1=H, 2=W, 3=D); [2] is unsigned load.
- imm  in  12  signed offset.
- op0  in  XLEN  base register.
- op1  in  XLEN  store source register.
- mem_req  out  1  memory request.
- mem_we  out  1  1 means store.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  XLEN  store data, shifted into lanes.
- mem_be  out  XLEN/8  byte enables.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  XLEN  full-width read word.
- res_valid  out  1  one-cycle completion pulse.
- res_data  out  XLEN  extended load data; 0 for stores and faults.
- misalign  out  1  qualifies res_valid: access misaligned, not issued.
- fault  out  1  qualifies res_valid: timeout (LSU_TIMEOUT_EN only).

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE. All outputs 0, except in_ready=1 once in IDLE. Reset mid-transaction drops mem_req next cycle; a late mem_rvalid in IDLE is ignored.
- in_ready = (state==IDLE). Accept occurs when in_valid & in_ready. All inputs are registered at accept.
- Address: EA = op0 + sign_extend(imm) to XLEN, truncated to ADDR_W. The low log2(XLEN/8) bits form the lane offset.
- Size: size = 1<<funct3[1:0].
  - funct3[1:0]=3 with XLEN=32 is illegal and is treated as misaligned.
  - Any opcode other than load/store is accepted and dropped silently: no outputs, stays IDLE.
- Misalign: EA mod size != 0, or size exceeds XLEN/8. Goes IDLE -> DONE with misalign=1 and no memory access.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE -> REQ on accepted aligned load/store. mem_req, mem_we, mem_addr, mem_wdata and mem_be are registered and stable for the whole REQ state.
  - REQ: hold until mem_gnt. Store -> DONE; load -> WAIT. mem_rvalid in REQ is ignored (earliest response is the cycle after grant).
  - WAIT: on mem_rvalid, capture mem_rdata, then -> DONE.
  - DONE: res_valid=1 for exactly one cycle, then -> IDLE. There is no result back-pressure.
- Store data: op1's low size bytes are shifted left by offset*8. mem_be = ((1<<size)-1) << offset. Unused lanes are 0.
- Load data: select size bytes at offset from mem_rdata, then zero-extend if funct3[2] else sign-extend to XLEN.
- Latency from accept edge T:
  - mem_req high at T+1.
  - With immediate gnt and rvalid, load res_valid at T+3; store at T+2.
  - Misaligned access: res_valid at T+1.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - On reaching TIMEOUT_CYC: mem_req drops, -> DONE with fault=1 and res_data=0.
  - A late mem_rvalid after this is ignored.
- Undefined: no counter. The unit waits indefinitely. fault is tied to 0.

Test Plan:
- Accept LW with op0=0x1000, imm=0xFFC, gnt at T+1, rvalid at T+2 with rdata=0xDEADBEEF -> mem_addr=0x0FFC, mem_be=4'hF, res_valid at T+3, res_data=0xDEADBEEF.
- LB with EA=0x2003, rdata=0x80AABBCC -> mem_be=4'h8, res_data=0xFFFFFF80. Same access as LBU -> res_data=0x00000080.
- SH with op1=0x1234ABCD, EA=0x0102 -> mem_we=1, mem_be=4'hC, mem_wdata=0xABCD0000, res_valid at T+2.
- LW at EA=0x0006 -> no mem_req, res_valid and misalign at T+1, res_data=0.
- mem_gnt held low 5 cycles -> mem_req and mem_addr stable throughout, in_ready=0. Assert rst_n=0 in WAIT -> next cycle mem_req=0, in_ready=1, no res_valid.
- With LSU_TIMEOUT_EN and TIMEOUT_CYC=8, no gnt -> res_valid and fault at cycle 8 after entering REQ. Subsequent rvalid is ignored.
